// File: rtl/dcache_ctrl_pkg.sv
// Shared types, address-split widths and helpers for the data cache controller.
// Default geometry: 16 lines of 256 bits, byte addresses split as tag | index | word | byte.
package dcache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB_REQ,
        RF_REQ,
        FILL
    } state_e;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int INDEX_W    = 4;
    localparam int TAG_W      = 32 - OFFSET_W - INDEX_W;

    function automatic logic [31:0] line_addr(input logic [31-OFFSET_W:0] line_num);
        return {line_num, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for a direct-mapped cache: combinational read port,
// one clocked write port doing either a full-line fill or a single-word store.
module dcache_line_array
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_BITS  = 23,
    parameter int LINE_BITS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  fill_en,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [LINE_BITS-1:0]  fill_line,
    input  logic                  word_en,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [31:0]           word_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tags and data survive reset; clearing valid is enough to invalidate them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (word_en) begin
            data_q[idx][{word_sel, 5'd0} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the MEM stage,
// with dirty-line writeback and line refill over a req/ack off-chip handshake.
//
// state  | meaning
// IDLE   | serve hits; on a miss stall and pick writeback or refill
// WB_REQ | victim line offered to memory, waiting for ack
// RF_REQ | refill requested, waiting for ack and line data
// FILL   | captured line written into the array; next cycle replays as a hit
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 1 << INDEX_W,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_read_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int TAG_BITS = TAG_W + INDEX_W - IDX_W;

    state_e state_q, state_d;

    logic [IDX_W-1:0]      idx;
    logic [TAG_BITS-1:0]   tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  unused_byte_bits;

    logic                  rd_valid, rd_dirty, hit, cpu_req;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic [LINE_BITS-1:0]  fill_q;
    logic                  fill_en, word_en;

    assign idx              = cpu_addr_i[OFFSET_W +: IDX_W];
    assign tag              = cpu_addr_i[31 -: TAG_BITS];
    assign word_sel         = cpu_addr_i[2 +: WORD_SEL_W];
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    assign cpu_req = cpu_read_i | cpu_write_i;
    assign hit     = rd_valid && (rd_tag == tag);

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_BITS  (TAG_BITS),
        .LINE_BITS (LINE_BITS)
    ) u_lines (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .fill_en   (fill_en),
        .fill_tag  (tag),
        .fill_line (fill_q),
        .word_en   (word_en),
        .word_sel  (word_sel),
        .word_data (cpu_wdata_i)
    );

    always_comb begin
        state_d     = state_q;
        fill_en     = 1'b0;
        word_en     = 1'b0;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        word_en = cpu_write_i;
                        if (!cpu_write_i) begin
                            cpu_rdata_o = rd_line[{word_sel, 5'd0} +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = (rd_valid && rd_dirty) ? WB_REQ : RF_REQ;
                    end
                end
            end
            WB_REQ: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) state_d = RF_REQ;
            end
            RF_REQ: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) state_d = FILL;
            end
            FILL: begin
                cpu_stall_o = 1'b1;
                fill_en     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs load only on entry to a request state, so they hold until ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_o <= (state_d == WB_REQ) || (state_d == RF_REQ);
            if (state_d != state_q) begin
                case (state_d)
                    WB_REQ: begin
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= line_addr({rd_tag, idx});
                        mem_wdata_o <= rd_line;
                    end
                    RF_REQ: begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= line_addr({tag, idx});
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == RF_REQ && mem_ack_i) begin
            fill_q <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a line-level cache model predicts stall length,
// read data and the off-chip transaction sequence; a memory responder acks with set delays.
module tb_dcache_ctrl;
    import dcache_ctrl_pkg::*;

    localparam int NL = 1 << INDEX_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_read, cpu_write;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_stall;
    logic         mem_req, mem_write, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;

    logic         resp_ack = 1'b0;
    logic         manual_ack = 1'b0;
    assign mem_ack = resp_ack | manual_ack;

    dcache_ctrl #(.NUM_LINES(NL), .LINE_BITS(256)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_read_i  (cpu_read),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Off-chip memory: lines never written back read as 0xA5000000 | byte address.
    logic [255:0] bk [logic [31:0]];

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] l;
        if (bk.exists(la)) return bk[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA500_0000 | (la + 32'(w * 4));
        return l;
    endfunction

    int           wb_delay = 2, rf_delay = 2;
    int           n_wb = 0, n_rf = 0;
    logic [31:0]  last_wb_addr = '0, last_rf_addr = '0;
    logic [255:0] last_wb_data = '0;

    initial begin
        int cnt;
        cnt = 0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                cnt = 0;
            end
            if (mem_req && !rst) begin
                cnt++;
                if (cnt == (mem_write ? wb_delay : rf_delay)) begin
                    resp_ack = 1'b1;
                    if (mem_write) begin
                        bk[mem_addr] = mem_wdata;
                        n_wb++;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end else begin
                        mem_rdata = get_line(mem_addr);
                        n_rf++;
                        last_rf_addr = mem_addr;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Model state and per-access expectations
    logic             m_valid [NL];
    logic             m_dirty [NL];
    logic [TAG_W-1:0] m_tag   [NL];
    logic [255:0]     m_data  [NL];

    logic             exp_wr   [2];
    logic [31:0]      exp_addr [2];
    logic [255:0]     exp_data [2];
    int               exp_n = 0, exp_stall = 0;
    logic [31:0]      exp_rdata = '0;
    int               acc_id = 0, done_id = 0, exp_ptr = 0;
    int               obs_stall = 0;
    logic [31:0]      obs_rdata = '0;
    logic             chk_on = 1'b0;

    initial begin
        int seen_id, cyc, stall_cnt;
        seen_id = 0; cyc = 0; stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (chk_on && !rst) begin
                if (acc_id != seen_id) begin
                    seen_id = acc_id; cyc = 0; exp_ptr = 0; stall_cnt = 0;
                end
                if (done_id != acc_id) begin
                    if (cpu_stall) stall_cnt++;
                    if (cyc < exp_stall) begin
                        chk("stall_high", cpu_stall, 1'b1);
                        chk("rdata_while_stalled", cpu_rdata, 0);
                    end else begin
                        chk("stall_low_at_hit", cpu_stall, 1'b0);
                        chk("rdata", cpu_rdata, exp_rdata);
                        obs_rdata = cpu_rdata;
                        obs_stall = stall_cnt;
                        done_id   = acc_id;
                    end
                    cyc++;
                end
                if (mem_req) begin
                    if (exp_ptr >= exp_n) begin
                        chk("unexpected_mem_req", mem_req, 1'b0);
                    end else begin
                        chk("mem_write", mem_write, exp_wr[exp_ptr]);
                        chk("mem_addr", mem_addr, exp_addr[exp_ptr]);
                        if (exp_wr[exp_ptr]) chk("mem_wdata", mem_wdata, exp_data[exp_ptr]);
                        if (mem_ack) exp_ptr++;
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int wbd, input int rfd);
        int               idx, ws, n;
        logic [TAG_W-1:0] tg;
        logic [31:0]      la;
        idx = int'(addr[OFFSET_W +: INDEX_W]);
        ws  = int'(addr[4:2]);
        tg  = addr[31 -: TAG_W];
        la  = {addr[31:OFFSET_W], 5'd0};
        @(posedge clk);
        #1;
        exp_n = 0;
        exp_stall = 0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_wr[0]   = 1'b1;
                exp_addr[0] = {m_tag[idx], addr[OFFSET_W +: INDEX_W], 5'd0};
                exp_data[0] = m_data[idx];
                exp_n       = 1;
                exp_stall   = wbd;
            end
            exp_wr[exp_n]   = 1'b0;
            exp_addr[exp_n] = la;
            exp_data[exp_n] = '0;
            exp_n++;
            exp_stall += rfd + 2;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = get_line(la);
        end
        if (wr) begin
            m_data[idx][ws*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
            exp_rdata = '0;
        end else begin
            exp_rdata = m_data[idx][ws*32 +: 32];
        end
        wb_delay  = wbd;
        rf_delay  = rfd;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        acc_id++;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (done_id != acc_id && n < 400);
        if (done_id != acc_id) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", addr, n);
        end
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        chk("txn_count", exp_ptr, exp_n);
    endtask

    initial begin
        int n, wb0, rf0;
        rst = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_mem_write", mem_write, 1'b0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_stall", cpu_stall, 1'b0);
        chk("reset_rdata", cpu_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;

        // Cold read, ack on the third cycle of req
        do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 2, 3);
        chk("cold_stall_cycles", obs_stall, 5);
        chk("cold_refill_addr", last_rf_addr, 32'h0000_0040);
        chk("cold_rdata", obs_rdata, 32'hA500_0044);
        chk("cold_no_wb", n_wb, 0);

        do_access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 2, 2);
        chk("store_hit_stall", obs_stall, 0);
        do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 2, 2);
        chk("load_after_store", obs_rdata, 32'hDEAD_BEEF);

        // Dirty conflict miss
        do_access(1'b1, 1'b0, 32'h0000_0244, 32'h0, 2, 2);
        chk("dirty_wb_addr", last_wb_addr, 32'h0000_0040);
        chk("dirty_wb_word1", last_wb_data[63:32], 32'hDEAD_BEEF);
        chk("dirty_refill_addr", last_rf_addr, 32'h0000_0240);
        chk("dirty_rdata", obs_rdata, 32'hA500_0244);
        chk("dirty_stall_cycles", obs_stall, 6);

        // Clean conflict misses: refills only
        wb0 = n_wb;
        rf0 = n_rf;
        do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 2, 2);
        chk("refetched_store_data", obs_rdata, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0000_0240, 32'h0, 2, 2);
        chk("clean_conflict_wb_count", n_wb - wb0, 0);
        chk("clean_conflict_rf_count", n_rf - rf0, 2);

        // Read and write together acts as a write-allocate store
        do_access(1'b1, 1'b1, 32'h0000_1048, 32'h1234_5678, 2, 2);
        do_access(1'b1, 1'b0, 32'h0000_1048, 32'h0, 2, 2);
        chk("rw_store_readback", obs_rdata, 32'h1234_5678);

        // Long ack hold-off on both writeback and refill
        do_access(1'b1, 1'b0, 32'h0000_1248, 32'h0, 20, 20);
        chk("slow_wb_addr", last_wb_addr, 32'h0000_1040);
        chk("slow_wb_word2", last_wb_data[95:64], 32'h1234_5678);
        chk("slow_stall_cycles", obs_stall, 42);
        chk("slow_rdata", obs_rdata, 32'hA500_1248);

        // Reset while a refill is outstanding, then a stray ack
        chk_on = 1'b0;
        @(posedge clk);
        #1;
        rf_delay = 1000;
        cpu_read = 1'b1;
        cpu_addr = 32'h0000_3004;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        chk("rst_test_req_rise", mem_req, 1'b1);
        @(negedge clk);
        chk("rst_test_req_addr", mem_addr, 32'h0000_3000);
        chk("rst_test_stall", cpu_stall, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        manual_ack = 1'b1;
        @(negedge clk);
        chk("after_rst_mem_req", mem_req, 1'b0);
        chk("after_rst_mem_write", mem_write, 1'b0);
        chk("after_rst_mem_addr", mem_addr, 0);
        chk("after_rst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        manual_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_no_req", mem_req, 1'b0);
        chk("late_ack_no_stall", cpu_stall, 1'b0);
        model_reset();
        chk_on = 1'b1;
        rf0 = n_rf;
        do_access(1'b1, 1'b0, 32'h0000_3004, 32'h0, 2, 2);
        chk("post_rst_refill_addr", last_rf_addr, 32'h0000_3000);
        chk("post_rst_stall_cycles", obs_stall, 4);
        chk("post_rst_rdata", obs_rdata, 32'hA500_3004);
        do_access(1'b1, 1'b0, 32'h0000_1248, 32'h0, 2, 2);
        chk("post_rst_old_line_misses", n_rf - rf0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
